// File: rtl/ternary_neuron_popcount_sched.sv
// Ternary neuron sequencer: streams positive then negative 18-bit chunks through
// a shared external popcount unit, accumulates a signed sum and thresholds it to a trit.
module ternary_neuron_popcount_sched #(
   parameter int NCHUNK = 4,
   parameter int ACC_W  = 10,
   parameter int THR_HI = 2,
   parameter int THR_LO = -2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCHUNK*18-1:0]   in_pos,
   input  logic [NCHUNK*18-1:0]   in_neg,
   output logic [17:0]            pc_chunk,
   input  logic [4:0]             pc_count,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             out_trit,
   output logic [ACC_W-1:0]       out_sum,
   output logic                   busy
);

   localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NCHUNK - 1);
   localparam logic signed [ACC_W-1:0] THR_HI_S = ACC_W'(THR_HI);
   localparam logic signed [ACC_W-1:0] THR_LO_S = ACC_W'(THR_LO);

   typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_t;

   state_t                   state;
   logic [NCHUNK*18-1:0]     pos_reg;
   logic [NCHUNK*18-1:0]     neg_reg;
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc;

   logic [IDX_W-1:0]         idx_nxt;
   logic signed [ACC_W-1:0]  acc_add;
   logic signed [ACC_W-1:0]  acc_sub;

   always_comb begin
      idx_nxt = idx + 1'b1;
      acc_add = acc + ACC_W'(pc_count);
      acc_sub = acc - ACC_W'(pc_count);
   end

   function automatic logic [1:0] trit_of(input logic signed [ACC_W-1:0] s);
      if (s >= THR_HI_S)      return 2'b01;
      else if (s <= THR_LO_S) return 2'b11;
      else                    return 2'b00;
   endfunction

   // pc_chunk is registered one step ahead so it always presents the chunk
   // belonging to the current (state, idx) while pc_count is accumulated.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_trit  <= '0;
         out_sum   <= '0;
         pc_chunk  <= '0;
         busy      <= 1'b0;
         idx       <= '0;
         acc       <= '0;
         pos_reg   <= '0;
         neg_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  pos_reg  <= in_pos;
                  neg_reg  <= in_neg;
                  acc      <= '0;
                  idx      <= '0;
                  pc_chunk <= in_pos[17:0];
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= POS;
               end
            end
            POS: begin
               acc <= acc_add;
               if (idx == IDX_LAST) begin
                  idx      <= '0;
                  pc_chunk <= neg_reg[17:0];
                  state    <= NEG;
               end else begin
                  idx      <= idx_nxt;
                  pc_chunk <= pos_reg[18*idx_nxt +: 18];
               end
            end
            NEG: begin
               acc <= acc_sub;
               if (idx == IDX_LAST) begin
                  idx       <= '0;
                  pc_chunk  <= '0;
                  busy      <= 1'b0;
                  out_sum   <= acc_sub;
                  out_trit  <= trit_of(acc_sub);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx      <= idx_nxt;
                  pc_chunk <= neg_reg[18*idx_nxt +: 18];
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_neuron_popcount_sched.sv
// Bench for ternary_neuron_popcount_sched: directed and random vectors against a
// population-count reference, with backpressure, reset abort and a saturated popcount unit.
module tb_ternary_neuron_popcount_sched;

   localparam int NCHUNK = 4;
   localparam int ACC_W  = 10;
   localparam int THR_HI = 2;
   localparam int THR_LO = -2;
   localparam int W      = NCHUNK * 18;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_pos = '0;
   logic [W-1:0]     in_neg = '0;
   logic [17:0]      pc_chunk;
   logic [4:0]       pc_count;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [1:0]       out_trit;
   logic [ACC_W-1:0] out_sum;
   logic             busy;
   logic             force31 = 1'b0;

   int checks = 0;
   int errors = 0;

   ternary_neuron_popcount_sched #(
      .NCHUNK(NCHUNK),
      .ACC_W (ACC_W),
      .THR_HI(THR_HI),
      .THR_LO(THR_LO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pos   (in_pos),
      .in_neg   (in_neg),
      .pc_chunk (pc_chunk),
      .pc_count (pc_count),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_trit (out_trit),
      .out_sum  (out_sum),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // exact popcount unit, or a saturated approximate one
   always_comb pc_count = force31 ? 5'd31 : 5'($countones(pc_chunk));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_trit(input int s);
      if (s >= THR_HI)      return 2'b01;
      else if (s <= THR_LO) return 2'b11;
      else                  return 2'b00;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input logic [W-1:0] pos, input logic [W-1:0] neg,
                          input int stall, input bit hold_valid);
      int s;
      int n;
      logic [17:0] ex [2*NCHUNK];
      logic [ACC_W-1:0] es;
      logic [1:0] et;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("ready_wait", W'(in_ready), W'(1));
      s  = force31 ? 0 : ($countones(pos) - $countones(neg));
      es = ACC_W'(s);
      et = ref_trit(s);
      for (int i = 0; i < NCHUNK; i++) begin
         ex[i]          = pos[18*i +: 18];
         ex[NCHUNK + i] = neg[18*i +: 18];
      end
      in_pos    = pos;
      in_neg    = neg;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      step();
      if (hold_valid) begin
         in_pos = ~pos;
         in_neg = ~neg;
      end else begin
         in_valid = 1'b0;
      end
      for (int i = 0; i < 2*NCHUNK; i++) begin
         chk($sformatf("chunk%0d", i), W'(pc_chunk), W'(ex[i]));
         chk("busy_hi", W'(busy), W'(1));
         chk("in_ready_busy", W'(in_ready), W'(0));
         chk("out_valid_busy", W'(out_valid), W'(0));
         step();
      end
      chk("out_valid", W'(out_valid), W'(1));
      chk("out_sum", W'(out_sum), W'(es));
      chk("out_trit", W'(out_trit), W'(et));
      chk("pc_chunk_done", W'(pc_chunk), W'(0));
      chk("busy_done", W'(busy), W'(0));
      chk("in_ready_done", W'(in_ready), W'(0));
      if (stall > 0) begin
         for (int k = 0; k < stall; k++) begin
            step();
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_sum", W'(out_sum), W'(es));
            chk("hold_trit", W'(out_trit), W'(et));
            chk("hold_in_ready", W'(in_ready), W'(0));
         end
         out_ready = 1'b1;
      end
      step();
      out_ready = 1'b0;
      chk("post_valid", W'(out_valid), W'(0));
      chk("post_in_ready", W'(in_ready), W'(1));
      chk("post_busy", W'(busy), W'(0));
      in_valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] p;
      logic [W-1:0] q;

      repeat (3) step();
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_trit", W'(out_trit), W'(0));
      chk("rst_out_sum", W'(out_sum), W'(0));
      chk("rst_pc_chunk", W'(pc_chunk), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      chk("out_ready_idle", W'(out_valid), W'(0));
      out_ready = 1'b0;

      run_vec('1, '0, 0, 1'b0);
      chk("sum_72", W'(out_sum), W'(10'd72));
      run_vec('0, '1, 0, 1'b0);
      chk("sum_m72", W'(out_sum), W'(10'h3B8));
      run_vec(W'(72'h3), W'(1) << 54, 0, 1'b0);
      run_vec(W'(72'h7), W'(1) << 54, 0, 1'b0);
      run_vec('0, W'(72'h3), 0, 1'b0);
      run_vec(W'(72'h5), W'(72'h1) << 20, 5, 1'b1);

      for (int t = 0; t < 12; t++) begin
         p = W'({$urandom(), $urandom(), $urandom()}) & W'({$urandom(), $urandom(), $urandom()});
         q = W'({$urandom(), $urandom(), $urandom()}) & W'({$urandom(), $urandom(), $urandom()});
         if (t >= 6) begin
            p = p & W'({$urandom(), $urandom(), $urandom()}) & W'({$urandom(), $urandom(), $urandom()});
            q = q & W'({$urandom(), $urandom(), $urandom()}) & W'({$urandom(), $urandom(), $urandom()});
         end
         run_vec(p, q, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      force31 = 1'b1;
      run_vec(W'({$urandom(), $urandom(), $urandom()}), W'({$urandom(), $urandom(), $urandom()}), 1, 1'b0);
      force31 = 1'b0;

      // reset while in NEG discards the operation
      in_pos   = '1;
      in_neg   = '0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      chk("pre_abort_busy", W'(busy), W'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", W'(in_ready), W'(1));
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_out_valid", W'(out_valid), W'(0));
      chk("abort_out_sum", W'(out_sum), W'(0));
      chk("abort_pc_chunk", W'(pc_chunk), W'(0));
      for (int k = 0; k < 12; k++) begin
         step();
         chk("abort_no_valid", W'(out_valid), W'(0));
      end

      run_vec(W'(72'h1) << 40, '0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
